branch_resolve_unit: RTL and testbench

- EX-stage consumer of next-PC predictions: carries each fetched instruction's prediction (taken flag and target) from IF through ID to EX.
- In EX, compares the prediction against the actual branch outcome, raises mispredict with the corrected PC, and issues a registered update to the predictor table.
- Sits beside the hazard unit. Its mispredict output drives the IF/ID and ID/EX flushes and the NPC override; its upd_* outputs feed the predictor's write port.

---
 rtl/bp_pkg.sv | 19 +
 rtl/branch_resolve_unit_if.sv | 23 ++
 rtl/bp_pred_stage.sv | 21 ++
 rtl/branch_resolve_unit.sv | 115 +++++++++++
 tb/tb_branch_resolve_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared branch-prediction types and constants, used by the resolve unit and the predictor.
package bp_pkg;

  localparam int BP_XLEN = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic               valid;
    logic               pred_taken;
    logic [BP_XLEN-1:0] pred_target;
  } bp_pred_t;

  typedef struct packed {
    logic [BP_XLEN-1:0] pc;
    logic               taken;
    logic [BP_XLEN-1:0] target;
  } bp_upd_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Resolve-unit result bundle: fetch redirect to the hazard unit and write port to the predictor.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);

  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;

  modport master (
    output mispredict, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_target
  );

  modport slave (
    input mispredict, redirect_pc,
    input upd_valid, upd_pc, upd_taken, upd_target
  );

endinterface

// File: rtl/bp_pred_stage.sv
// One pipeline register for a prediction record; flush beats stall beats advance.
module bp_pred_stage
  import bp_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  logic     stall,
  input  bp_pred_t d,
  output bp_pred_t q
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries IF predictions to EX, flags mispredicts with the corrected PC and writes the predictor.
// Define BP_PERF_CNT_EN to add the perf_branches / perf_mispredicts counters.
module branch_resolve_unit
  import bp_pkg::*;
#(
  // Must match bp_pkg::BP_XLEN; the prediction records are sized from the package.
  parameter int XLEN    = BP_XLEN,
  parameter int PC_STEP = bp_pkg::PC_STEP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_if,
  input  logic            pred_taken_if,
  input  logic [XLEN-1:0] pred_target_if,
  input  logic            stall_id,
  input  logic            flush_id,
  input  logic            stall_ex,
  input  logic            flush_ex,
  input  logic [XLEN-1:0] pc_ex,
  input  logic            is_branch_ex,
  input  logic            br_taken_ex,
  input  logic [XLEN-1:0] br_target_ex,
  branch_resolve_unit_if.master rsp
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  bp_pred_t        if_pred;
  bp_pred_t        id_pred;
  bp_pred_t        ex_pred;
  logic            ex_live;
  logic            live_branch;
  logic            br_mismatch;
  logic            ex_mispredict;
  logic [XLEN-1:0] seq_pc;
  logic            upd_valid_q;
  bp_upd_t         upd_q;

  assign if_pred = '{valid: valid_if, pred_taken: pred_taken_if, pred_target: pred_target_if};

  bp_pred_stage u_id_stage (
    .clk   (clk),
    .reset (reset),
    .flush (flush_id),
    .stall (stall_id),
    .d     (if_pred),
    .q     (id_pred)
  );

  bp_pred_stage u_ex_stage (
    .clk   (clk),
    .reset (reset),
    .flush (flush_ex),
    .stall (stall_ex),
    .d     (id_pred),
    .q     (ex_pred)
  );

  assign ex_live     = ex_pred.valid & ~stall_ex;
  assign live_branch = ex_live & is_branch_ex;
  assign seq_pc      = pc_ex + XLEN'(PC_STEP);

  // Target only matters when both sides agree the branch is taken.
  always_comb begin
    br_mismatch = 1'b0;
    if (ex_pred.pred_taken != br_taken_ex) begin
      br_mismatch = 1'b1;
    end else if (br_taken_ex && (ex_pred.pred_target != br_target_ex)) begin
      br_mismatch = 1'b1;
    end
  end

  // A non-branch predicted taken is an aliased table hit and must fall through.
  assign ex_mispredict = ex_live & (is_branch_ex ? br_mismatch : ex_pred.pred_taken);

  assign rsp.mispredict  = ex_mispredict;
  assign rsp.redirect_pc = (is_branch_ex && br_taken_ex) ? br_target_ex : seq_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_valid_q <= 1'b0;
      upd_q       <= '0;
    end else begin
      upd_valid_q <= live_branch;
      if (live_branch) begin
        upd_q <= '{pc: pc_ex, taken: br_taken_ex, target: br_target_ex};
      end
    end
  end

  assign rsp.upd_valid  = upd_valid_q;
  assign rsp.upd_pc     = upd_q.pc;
  assign rsp.upd_taken  = upd_q.taken;
  assign rsp.upd_target = upd_q.target;

`ifdef BP_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (live_branch && (perf_branches != 32'hFFFF_FFFF)) begin
        perf_branches <= perf_branches + 32'd1;
      end
      if (ex_mispredict && (perf_mispredicts != 32'hFFFF_FFFF)) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit; perf counters are checked when BP_PERF_CNT_EN is defined.
module tb_branch_resolve_unit;
  import bp_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        isb;
    logic        bt;
    logic [31:0] btgt;
    logic        mis;
    logic [31:0] rpc;
  } vec_t;

  typedef struct {
    logic        mis;
    logic [31:0] rpc;
  } ex_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_if, pred_taken_if;
  logic [31:0] pred_target_if;
  logic        stall_id, flush_id, stall_ex, flush_ex;
  logic [31:0] pc_ex;
  logic        is_branch_ex, br_taken_ex;
  logic [31:0] br_target_ex;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic chk_ex    = 1'b0;
  logic mon_quiet = 1'b0;

  vec_t    v[8];
  ex_exp_t ex_q[$];
  bp_upd_t upd_q[$];

  branch_resolve_unit_if #(.XLEN(32)) bru_if ();

  branch_resolve_unit dut (
    .clk            (clk),
    .reset          (reset),
    .valid_if       (valid_if),
    .pred_taken_if  (pred_taken_if),
    .pred_target_if (pred_target_if),
    .stall_id       (stall_id),
    .flush_id       (flush_id),
    .stall_ex       (stall_ex),
    .flush_ex       (flush_ex),
    .pc_ex          (pc_ex),
    .is_branch_ex   (is_branch_ex),
    .br_taken_ex    (br_taken_ex),
    .br_target_ex   (br_target_ex),
    .rsp            (bru_if)
`ifdef BP_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever EX is scored or an update strobe appears.
  always @(negedge clk) begin
    ex_exp_t e;
    bp_upd_t u;
    if (chk_ex) begin
      if (ex_q.size() == 0) begin
        chk("ex_queue_underflow", 32'd1, 32'd0);
      end else begin
        e = ex_q.pop_front();
        chk("mispredict", {31'd0, bru_if.mispredict}, {31'd0, e.mis});
        if (e.mis) chk("redirect_pc", bru_if.redirect_pc, e.rpc);
      end
    end else if (!mon_quiet) begin
      chk("idle_mispredict", {31'd0, bru_if.mispredict}, 32'd0);
    end
    if (bru_if.upd_valid === 1'b1) begin
      if (upd_q.size() == 0) begin
        chk("unexpected_upd_valid", 32'd1, 32'd0);
      end else begin
        u = upd_q.pop_front();
        chk("upd_pc", bru_if.upd_pc, u.pc);
        chk("upd_taken", {31'd0, bru_if.upd_taken}, {31'd0, u.taken});
        chk("upd_target", bru_if.upd_target, u.target);
      end
    end
  end

  task automatic drive_if(input int i);
    valid_if       = 1'b1;
    pred_taken_if  = v[i].pt;
    pred_target_if = v[i].ptgt;
  endtask

  task automatic clear_if();
    valid_if       = 1'b0;
    pred_taken_if  = 1'b0;
    pred_target_if = '0;
  endtask

  // live=0 marks a stalled EX cycle: nothing may fire.
  task automatic drive_ex(input int i, input bit live);
    pc_ex        = v[i].pc;
    is_branch_ex = v[i].isb;
    br_taken_ex  = v[i].bt;
    br_target_ex = v[i].btgt;
    chk_ex       = 1'b1;
    if (live) begin
      ex_q.push_back('{mis: v[i].mis, rpc: v[i].rpc});
      if (v[i].isb) upd_q.push_back('{pc: v[i].pc, taken: v[i].bt, target: v[i].btgt});
    end else begin
      ex_q.push_back('{mis: 1'b0, rpc: 32'd0});
    end
  endtask

  task automatic clear_ex();
    pc_ex        = '0;
    is_branch_ex = 1'b0;
    br_taken_ex  = 1'b0;
    br_target_ex = '0;
    chk_ex       = 1'b0;
  endtask

  task automatic burst(input int s, input int n);
    for (int k = 0; k < n + 2; k++) begin
      @(posedge clk); #1;
      if (k < n) drive_if(s + k); else clear_if();
      if (k >= 2) drive_ex(s + k - 2, 1'b1); else clear_ex();
    end
    @(posedge clk); #1;
    clear_if();
    clear_ex();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v[0] = '{pc: 32'h40,       pt: 1, ptgt: 32'h100,  isb: 1, bt: 1, btgt: 32'h100, mis: 0, rpc: 32'h0};
    v[1] = '{pc: 32'h80,       pt: 0, ptgt: 32'h0,    isb: 1, bt: 1, btgt: 32'h20,  mis: 1, rpc: 32'h20};
    v[2] = '{pc: 32'h80,       pt: 1, ptgt: 32'h20,   isb: 1, bt: 0, btgt: 32'h20,  mis: 1, rpc: 32'h84};
    v[3] = '{pc: 32'h300,      pt: 0, ptgt: 32'h0,    isb: 1, bt: 0, btgt: 32'h400, mis: 0, rpc: 32'h0};
    v[4] = '{pc: 32'h40,       pt: 1, ptgt: 32'h100,  isb: 1, bt: 1, btgt: 32'h100, mis: 0, rpc: 32'h0};
    v[5] = '{pc: 32'hFFFFFFFC, pt: 1, ptgt: 32'h1234, isb: 0, bt: 0, btgt: 32'h0,   mis: 1, rpc: 32'h0};
    v[6] = '{pc: 32'h200,      pt: 1, ptgt: 32'h300,  isb: 1, bt: 1, btgt: 32'h304, mis: 1, rpc: 32'h304};
    v[7] = '{pc: 32'h10,       pt: 0, ptgt: 32'h0,    isb: 0, bt: 0, btgt: 32'h0,   mis: 0, rpc: 32'h0};

    reset = 1'b1;
    stall_id = 1'b0; flush_id = 1'b0; stall_ex = 1'b0; flush_ex = 1'b0;
    clear_if();
    clear_ex();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mispredict", {31'd0, bru_if.mispredict}, 32'd0);
    chk("reset_upd_valid", {31'd0, bru_if.upd_valid}, 32'd0);
    chk("reset_upd_pc", bru_if.upd_pc, 32'd0);
    chk("reset_upd_taken", {31'd0, bru_if.upd_taken}, 32'd0);
    chk("reset_upd_target", bru_if.upd_target, 32'd0);

    // Five back-to-back branches, two mispredicted.
    burst(0, 5);
`ifdef BP_PERF_CNT_EN
    chk("perf_branches", perf_branches, 32'd5);
    chk("perf_mispredicts", perf_mispredicts, 32'd2);
`endif

    // Wrapping alias, target mismatch, harmless non-branch.
    burst(5, 3);

    // Branch held in EX for three cycles, fires once on release.
    @(posedge clk); #1 drive_if(1);
    @(posedge clk); #1 clear_if();
    @(posedge clk); #1 stall_id = 1'b1; stall_ex = 1'b1; drive_ex(1, 1'b0);
    @(posedge clk); #1 drive_ex(1, 1'b0);
    @(posedge clk); #1 drive_ex(1, 1'b0);
    @(posedge clk); #1 stall_id = 1'b0; stall_ex = 1'b0; drive_ex(1, 1'b1);
    @(posedge clk); #1 clear_ex();
    @(posedge clk); #1;

    // flush_ex while the branch sits in ID: it never reaches EX.
    @(posedge clk); #1 drive_if(1);
    @(posedge clk); #1 clear_if(); flush_ex = 1'b1;
    @(posedge clk); #1 flush_ex = 1'b0; drive_ex(1, 1'b0);
    @(posedge clk); #1 clear_ex();
    @(posedge clk); #1;

    // flush_id on the capture edge drops the IF instruction.
    @(posedge clk); #1 drive_if(2); flush_id = 1'b1;
    @(posedge clk); #1 clear_if(); flush_id = 1'b0;
    @(posedge clk); #1 drive_ex(2, 1'b0);
    @(posedge clk); #1 clear_ex();
    @(posedge clk); #1;

    // Reset during a live branch drops its update.
    @(posedge clk); #1 drive_if(1);
    @(posedge clk); #1 clear_if();
    @(posedge clk); #1 mon_quiet = 1'b1; reset = 1'b1;
    pc_ex = v[1].pc; is_branch_ex = 1'b1; br_taken_ex = v[1].bt; br_target_ex = v[1].btgt;
    @(posedge clk); #1 reset = 1'b0; clear_ex();
    chk("rst_mid_upd_valid", {31'd0, bru_if.upd_valid}, 32'd0);
    chk("rst_mid_upd_pc", bru_if.upd_pc, 32'd0);
    chk("rst_mid_mispredict", {31'd0, bru_if.mispredict}, 32'd0);
`ifdef BP_PERF_CNT_EN
    chk("rst_mid_perf_branches", perf_branches, 32'd0);
    chk("rst_mid_perf_mispredicts", perf_mispredicts, 32'd0);
`endif
    @(posedge clk); #1 mon_quiet = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ex_queue_drained", ex_q.size(), 32'd0);
    chk("upd_queue_drained", upd_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
